// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the pipeline/mul-div sources and the register file write port.
// WB_HAZARD_EN adds the decode-stage pending-register query signals.
interface regfile_wb_arbiter_if #(
   parameter int AW = 5,
   parameter int DW = 32,
   parameter int CW = 2
);
   logic          p_valid;
   logic [AW-1:0] p_addr;
   logic [DW-1:0] p_data;
   logic          m_valid;
   logic          m_ready;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic          we3;
   logic [AW-1:0] wa3;
   logic [DW-1:0] wd3;
   logic [CW-1:0] m_count;
`ifdef WB_HAZARD_EN
   logic [AW-1:0] q_addr1;
   logic [AW-1:0] q_addr2;
   logic          q_pend1;
   logic          q_pend2;

   modport master (
      output p_valid, p_addr, p_data, m_valid, m_addr, m_data, q_addr1, q_addr2,
      input  m_ready, we3, wa3, wd3, m_count, q_pend1, q_pend2
   );
   modport slave (
      input  p_valid, p_addr, p_data, m_valid, m_addr, m_data, q_addr1, q_addr2,
      output m_ready, we3, wa3, wd3, m_count, q_pend1, q_pend2
   );
`else
   modport master (
      output p_valid, p_addr, p_data, m_valid, m_addr, m_data,
      input  m_ready, we3, wa3, wd3, m_count
   );
   modport slave (
      input  p_valid, p_addr, p_data, m_valid, m_addr, m_data,
      output m_ready, we3, wa3, wd3, m_count
   );
`endif
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Merges pipeline writeback (priority) and a FIFO-buffered mul/div source onto the
// register file write port, with WAW kill of stale queued results. Option: WB_HAZARD_EN.
module regfile_wb_arbiter #(
   parameter int DEPTH = 2,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   regfile_wb_arbiter_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0]    addr_q [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [DEPTH-1:0] live_q;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             we3_r;
   logic [AW-1:0]    wa3_r;
   logic [DW-1:0]    wd3_r;

   logic p_wr;
   logic push;
   logic pop;

   // Ready depends only on the registered count, so no path from m_valid/p_valid.
   assign bus.m_ready = (count < CW'(DEPTH));
   assign bus.m_count = count;
   assign bus.we3     = we3_r;
   assign bus.wa3     = wa3_r;
   assign bus.wd3     = wd3_r;

   assign p_wr = bus.p_valid && (bus.p_addr != '0);
   assign push = bus.m_valid && bus.m_ready && (bus.m_addr != '0);
   assign pop  = !p_wr && (count != '0);

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; later assignments in the block win, which orders kill/pop/push.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         live_q <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (p_wr && (addr_q[i] == bus.p_addr)) live_q[i] <= 1'b0;
         end
         if (pop) begin
            live_q[rd_ptr] <= 1'b0;
            rd_ptr         <= rd_ptr + PW'(1);
         end
         // A same-cycle push is younger than the pipeline write, so it stays live.
         if (push) begin
            live_q[wr_ptr] <= 1'b1;
            wr_ptr         <= wr_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: payload storage is not reset; only the live bits and pointers need a
   // defined value, which keeps the data array as plain flops/RAM without reset muxes.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr] <= bus.m_addr;
         data_q[wr_ptr] <= bus.m_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         we3_r <= 1'b0;
         wa3_r <= '0;
         wd3_r <= '0;
      end else if (p_wr) begin
         we3_r <= 1'b1;
         wa3_r <= bus.p_addr;
         wd3_r <= bus.p_data;
      end else if (pop) begin
         we3_r <= live_q[rd_ptr];
         if (live_q[rd_ptr]) begin
            wa3_r <= addr_q[rd_ptr];
            wd3_r <= data_q[rd_ptr];
         end
      end else begin
         we3_r <= 1'b0;
      end
   end

`ifdef WB_HAZARD_EN
   logic hit1;
   logic hit2;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (live_q[i] && (addr_q[i] == bus.q_addr1)) hit1 = 1'b1;
         if (live_q[i] && (addr_q[i] == bus.q_addr2)) hit2 = 1'b1;
      end
   end

   assign bus.q_pend1 = (bus.q_addr1 != '0) && (hit1 || (we3_r && (wa3_r == bus.q_addr1)));
   assign bus.q_pend2 = (bus.q_addr2 != '0) && (hit2 || (we3_r && (wa3_r == bus.q_addr2)));
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed plan steps then random traffic,
// compared against a queue-based model of the writeback rules. Honours WB_HAZARD_EN.
module tb_regfile_wb_arbiter;
   localparam int DEPTH = 2;
   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      bit            live;
   } entry_t;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

   regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   entry_t        mq[$];
   logic          exp_we3 = 1'b0;
   logic [AW-1:0] exp_wa3 = '0;
   logic [DW-1:0] exp_wd3 = '0;
   int            n_checks = 0;
   int            n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_pend(input logic [AW-1:0] a);
      if (a == '0) return 1'b0;
      if (exp_we3 && exp_wa3 == a) return 1'b1;
      foreach (mq[i]) if (mq[i].live && mq[i].addr == a) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drive_idle();
      bus.p_valid = 1'b0;
      bus.p_addr  = '0;
      bus.p_data  = '0;
      bus.m_valid = 1'b0;
      bus.m_addr  = '0;
      bus.m_data  = '0;
   endtask

   // Called at a falling edge; pulses reset and releases it one cycle later.
   task automatic apply_reset();
      reset_n = 1'b0;
      drive_idle();
      #1;
      mq.delete();
      exp_we3 = 1'b0;
      exp_wa3 = '0;
      exp_wd3 = '0;
      check("rst_we3", 32'(bus.we3), 32'(exp_we3));
      check("rst_wa3", 32'(bus.wa3), 32'(exp_wa3));
      check("rst_wd3", bus.wd3, exp_wd3);
      check("rst_count", 32'(bus.m_count), 32'(mq.size()));
      check("rst_ready", 32'(bus.m_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // One clock: drive inputs, check pre-edge comb outputs, advance model, check after edge.
   task automatic step(input logic pv, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                       input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
      logic   ready;
      entry_t h;
      bus.p_valid = pv;
      bus.p_addr  = pa;
      bus.p_data  = pd;
      bus.m_valid = mv;
      bus.m_addr  = ma;
      bus.m_data  = md;
      #1;
      ready = (mq.size() < DEPTH);
      check("m_ready", 32'(bus.m_ready), 32'(ready));
`ifdef WB_HAZARD_EN
      check("q_pend1", 32'(bus.q_pend1), 32'(model_pend(bus.q_addr1)));
      check("q_pend2", 32'(bus.q_pend2), 32'(model_pend(bus.q_addr2)));
`endif
      if (pv && pa != '0) begin
         foreach (mq[i]) if (mq[i].addr == pa) mq[i].live = 1'b0;
         exp_we3 = 1'b1;
         exp_wa3 = pa;
         exp_wd3 = pd;
      end else if (mq.size() > 0) begin
         h = mq.pop_front();
         exp_we3 = h.live;
         if (h.live) begin
            exp_wa3 = h.addr;
            exp_wd3 = h.data;
         end
      end else begin
         exp_we3 = 1'b0;
      end
      if (mv && ready && ma != '0) mq.push_back('{ma, md, 1'b1});
      @(posedge clk);
      @(negedge clk);
      check("we3", 32'(bus.we3), 32'(exp_we3));
      check("wa3", 32'(bus.wa3), 32'(exp_wa3));
      check("wd3", bus.wd3, exp_wd3);
      check("m_count", 32'(bus.m_count), 32'(mq.size()));
   endtask

   initial begin
      drive_idle();
`ifdef WB_HAZARD_EN
      bus.q_addr1 = '0;
      bus.q_addr2 = '0;
`endif
      @(negedge clk);
      apply_reset();

      // Release from reset straight into a pipeline write.
      step(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0);
      check("rel_we3", 32'(bus.we3), 32'd1);
      check("rel_wa3", 32'(bus.wa3), 32'd3);
      check("rel_wd3", bus.wd3, 32'h11);

      // Basic mul/div path: two-cycle latency through the FIFO.
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hAAAA);
      check("md_count1", 32'(bus.m_count), 32'd1);
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      check("md_we3", 32'(bus.we3), 32'd1);
      check("md_wa3", 32'(bus.wa3), 32'd5);
      check("md_wd3", bus.wd3, 32'hAAAA);
      check("md_count0", 32'(bus.m_count), 32'd0);

      // Back-pressure under sustained pipeline writes, then in-order drain.
      step(1'b1, 5'd7, 32'h70, 1'b1, 5'd20, 32'hD1);
      step(1'b1, 5'd7, 32'h71, 1'b1, 5'd21, 32'hD2);
      check("bp_ready_low", 32'(bus.m_ready), 32'd0);
      step(1'b1, 5'd7, 32'h72, 1'b1, 5'd22, 32'hD3);
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd22, 32'hD3);
      check("bp_first_wa3", 32'(bus.wa3), 32'd20);
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd22, 32'hD3);
      check("bp_second_wa3", 32'(bus.wa3), 32'd21);
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      check("bp_third_wa3", 32'(bus.wa3), 32'd22);
      check("bp_ready_back", 32'(bus.m_ready), 32'd1);
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

      // WAW kill of a queued result by a later pipeline write.
      step(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h1);
      step(1'b1, 5'd4, 32'h44, 1'b1, 5'd10, 32'h2);
      step(1'b1, 5'd9, 32'h3, 1'b0, 5'd0, 32'h0);
      check("waw_p_wa3", 32'(bus.wa3), 32'd9);
      check("waw_p_wd3", bus.wd3, 32'h3);
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      check("waw_killed_we3", 32'(bus.we3), 32'd0);
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      check("waw_live_we3", 32'(bus.we3), 32'd1);
      check("waw_live_wa3", 32'(bus.wa3), 32'd10);
      check("waw_live_wd3", bus.wd3, 32'h2);

      // Register zero: ignored pipeline write lets the queue drain; zero push discarded.
      step(1'b1, 5'd6, 32'h66, 1'b1, 5'd11, 32'h55);
      step(1'b1, 5'd0, 32'hEE, 1'b1, 5'd0, 32'hBB);
      check("r0_drain_wa3", 32'(bus.wa3), 32'd11);
      check("r0_drain_wd3", bus.wd3, 32'h55);
      check("r0_count", 32'(bus.m_count), 32'd0);
      step(1'b1, 5'd0, 32'hEE, 1'b1, 5'd0, 32'hBB);
      check("r0_no_we3", 32'(bus.we3), 32'd0);
      check("r0_count_still", 32'(bus.m_count), 32'd0);

`ifdef WB_HAZARD_EN
      // Pending tracking follows a queued entry through its kill and the covering write.
      bus.q_addr1 = 5'd12;
      bus.q_addr2 = 5'd0;
      step(1'b1, 5'd4, 32'h44, 1'b1, 5'd12, 32'h77);
      check("hz_pend1_q", 32'(bus.q_pend1), 32'd1);
      check("hz_pend2_zero", 32'(bus.q_pend2), 32'd0);
      step(1'b1, 5'd12, 32'h99, 1'b0, 5'd0, 32'h0);
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      check("hz_pend1_clear", 32'(bus.q_pend1), 32'd0);
`endif

      // Mid-operation reset discards queued results.
      step(1'b1, 5'd2, 32'h22, 1'b1, 5'd13, 32'h13);
      step(1'b1, 5'd2, 32'h22, 1'b1, 5'd14, 32'h14);
      apply_reset();

      // Random traffic over a small address range to provoke collisions and kills.
      for (int n = 0; n < 400; n++) begin
`ifdef WB_HAZARD_EN
         bus.q_addr1 = AW'($urandom_range(0, 15));
         bus.q_addr2 = AW'($urandom_range(0, 15));
`endif
         if ($urandom_range(0, 99) == 0) begin
            apply_reset();
         end else begin
            step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
                 1'($urandom_range(0, 9) < 6), AW'($urandom_range(0, 15)), $urandom);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
